// File: rtl/register_file_mp.sv
// Multi-port register file with per-register busy scoreboard and a registered write-conflict flag.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_WR_PORTS-1:0]              wr_en,
    input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0]   wr_reg,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_reg,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]              rd_busy,
    input  logic                                 rsv_en,
    input  logic [ADDR_WIDTH-1:0]                rsv_reg,
    output logic                                 wr_conflict
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic                  wr_conflict_q;
    logic                  wr_conflict_d;

    function automatic logic idx_ok(input logic [ADDR_WIDTH-1:0] idx);
        return (idx != '0) && (int'(idx) < NUM_REGS);
    endfunction

    // Writes land in port order so the highest port wins; a reserve is applied last so it beats a write-release.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int i = 0; i < NUM_WR_PORTS; i++) begin
                if (wr_en[i] && (wr_reg[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                    regs_d[r] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    busy_d[r] = 1'b0;
                end
            end
            if (rsv_en && (rsv_reg == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
            for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
                if (wr_en[i] && wr_en[j] && idx_ok(wr_reg[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (wr_reg[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_reg[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Register 0 is never written, so its stored word stays at the reset value of zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_reg[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
                    rd_busy[p]                          = busy_q[r];
                end
            end
`ifdef WRITE_BYPASS_EN
            for (int i = 0; i < NUM_WR_PORTS; i++) begin
                if (wr_en[i] && idx_ok(wr_reg[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (wr_reg[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_reg[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    rd_busy[p] = rsv_en && (rsv_reg == rd_reg[p*ADDR_WIDTH +: ADDR_WIDTH]);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expected values, a negedge monitor checks them.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int NR = 20;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_reg;
    logic [2*DW-1:0] wr_data;
    logic [2*AW-1:0] rd_reg;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          rsv_en;
    logic [AW-1:0] rsv_reg;
    logic          wr_conflict;

    register_file_mp #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
        .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_reg(rsv_reg), .wr_conflict(wr_conflict)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            0: return rd_data[31:0];
            1: return rd_data[63:32];
            2: return {31'd0, rd_busy[0]};
            3: return {31'd0, rd_busy[1]};
            default: return {31'd0, wr_conflict};
        endcase
    endfunction

    // Monitor: pops every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = sample(e.kind);
            n_checks++;
            if (e.cyc != cycle || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cycle, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] r, input logic [DW-1:0] d);
        wr_en[p]              = 1'b1;
        wr_reg[p*AW +: AW]    = r;
        wr_data[p*DW +: DW]   = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] r);
        rd_reg[p*AW +: AW] = r;
    endtask

    task automatic expect_now(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cycle;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = '0; wr_reg = '0; wr_data = '0;
        rd_reg = '0; rsv_en = 1'b0; rsv_reg = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        set_rd(0, 5); set_rd(1, 0);
        expect_now(0, 32'h0, "reset_rd0");
        expect_now(2, 32'h0, "reset_busy0");
        expect_now(4, 32'h0, "reset_conflict");
        set_wr(0, 5, 32'hDEADBEEF);
        step(); idle();
        expect_now(0, 32'hDEADBEEF, "r5_written");
        rst = 1'b1;
        step(); rst = 1'b0;
        expect_now(0, 32'h0, "r5_after_reset");
        expect_now(2, 32'h0, "busy_after_reset");
        expect_now(4, 32'h0, "conflict_after_reset");

        // x0 immunity
        set_wr(0, 0, 32'hFFFFFFFF); set_rd(0, 0);
        step(); idle();
        rsv_en = 1'b1; rsv_reg = 0;
        expect_now(0, 32'h0, "x0_after_write");
        step(); idle();
        expect_now(0, 32'h0, "x0_after_rsv");
        expect_now(2, 32'h0, "x0_busy");
        expect_now(4, 32'h0, "x0_no_conflict");

        // Dual write
        set_wr(0, 3, 32'h11); set_wr(1, 7, 32'h22);
        step(); idle();
        set_rd(0, 3); set_rd(1, 7);
        expect_now(0, 32'h11, "dual_r3");
        expect_now(1, 32'h22, "dual_r7");
        expect_now(4, 32'h0, "dual_no_conflict");

        // Conflict on r9: port 1 wins
        set_wr(0, 9, 32'hAA); set_wr(1, 9, 32'hBB);
        step(); idle();
        set_rd(0, 9);
        expect_now(0, 32'hBB, "conflict_r9");
        expect_now(4, 32'h1, "conflict_set");
        step();
        expect_now(4, 32'h0, "conflict_clear");

        // Scoreboard
        set_rd(0, 4);
        rsv_en = 1'b1; rsv_reg = 4;
        expect_now(2, 32'h0, "r4_not_busy_yet");
        step(); idle();
        expect_now(2, 32'h1, "r4_reserved");
        step();
        set_wr(0, 4, 32'h55);
        step(); idle();
        expect_now(0, 32'h55, "r4_written");
        expect_now(2, 32'h0, "r4_released");
        rsv_en = 1'b1; rsv_reg = 4; set_wr(1, 4, 32'h66);
        step(); idle();
        expect_now(0, 32'h66, "r4_rsv_wr_data");
        expect_now(2, 32'h1, "r4_rsv_wins");

        // Bypass on r12
        set_rd(1, 12); set_wr(1, 12, 32'h1234);
`ifdef WRITE_BYPASS_EN
        expect_now(1, 32'h1234, "bypass_same_cycle");
`else
        expect_now(1, 32'h0, "no_bypass_old_value");
`endif
        expect_now(3, 32'h0, "bypass_busy");
        step(); idle();
        expect_now(1, 32'h1234, "r12_next_cycle");

        // Out-of-range index 25 and top register 19
        set_wr(0, 25, 32'h77); set_wr(1, 25, 32'h78);
        rsv_en = 1'b1; rsv_reg = 25;
        step(); idle();
        set_rd(0, 25);
        expect_now(0, 32'h0, "oor_read");
        expect_now(2, 32'h0, "oor_busy");
        expect_now(4, 32'h0, "oor_no_conflict");
        set_wr(0, 19, 32'h99);
        step(); idle();
        set_rd(1, 19);
        expect_now(1, 32'h99, "r19_top");
        expect_now(2, 32'h0, "oor_busy_later");

        step(); step();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
